// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver with 16x oversampling; presents the low 7 bits of each
// good frame as an ASCII character with a one-cycle newdata strobe.
module uart_ascii_rx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] datain,
  output logic       newdata,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [3:0] T_MID  = 4'd7;
  localparam logic [3:0] T_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [6:0]    datain_q, datain_d;
  logic          newdata_q, newdata_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign tick      = (dcnt_q == DIV_MAX);
  assign datain    = datain_q;
  assign newdata   = newdata_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

  // Synchroniser idles high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      datain_q    <= '0;
      newdata_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      datain_q    <= datain_d;
      newdata_q   <= newdata_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = tick ? '0 : dcnt_q + DW'(1);
    tcnt_d      = tick ? tcnt_q + 4'd1 : tcnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    datain_d    = datain_q;
    newdata_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Restart oversampling on the edge so sample points are frame-aligned.
        if (!rx_s_q) begin
          state_d = S_START;
          dcnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (tick && tcnt_q == T_MID) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && tcnt_q == T_LAST) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick && tcnt_q == T_LAST) begin
          if (rx_s_q) begin
            datain_d  = shift_q[6:0];
            newdata_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Directed bench for uart_ascii_rx: frame-level model of expected strobes
// checked every cycle, plus literal expectations per scenario.
module tb_uart_ascii_rx;

  localparam int BIT_CLK = 160;
  // Line falling edge to strobe-visible cycle: 2 sync + 1 detect + 8 + 9*16 ticks.
  localparam int STROBE_LAT = 3 + 80 + 160 * 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [6:0] datain;
  logic       newdata;
  logic       frame_err;
  logic       busy;

  uart_ascii_rx #(
    .CLK_HZ(1_600_000),
    .BAUD  (10_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .datain   (datain),
    .newdata  (newdata),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         err;
    logic [6:0] ch;
  } ev_t;

  ev_t        evq[$];
  logic [6:0] model_dat = 7'h00;
  int         checks = 0;
  int         failures = 0;
  int         nd_cnt = 0;
  int         fe_cnt = 0;
  int         nd_cyc[$];
  logic [6:0] nd_val[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  initial begin
    ev_t ev;
    logic exp_nd, exp_fe;
    forever begin
      @(negedge clk);
      exp_nd = 1'b0;
      exp_fe = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.err) exp_fe = 1'b1;
        else begin
          exp_nd    = 1'b1;
          model_dat = ev.ch;
        end
      end
      chk("newdata", 32'(newdata), 32'(exp_nd));
      chk("frame_err", 32'(frame_err), 32'(exp_fe));
      chk("datain", 32'(datain), 32'(model_dat));
      if (newdata) begin
        nd_cnt++;
        nd_cyc.push_back(cyc);
        nd_val.push_back(datain);
      end
      if (frame_err) fe_cnt++;
    end
  end

  task automatic tx_bit(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok, input int stop_len);
    ev_t ev;
    ev.at  = cyc + STROBE_LAT;
    ev.err = !stop_ok;
    ev.ch  = b[6:0];
    evq.push_back(ev);
    tx_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) tx_bit(b[i], BIT_CLK);
    tx_bit(stop_ok, stop_len);
  endtask

  initial begin
    int         n0;
    int         f0;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_datain", 32'(datain), 32'h00);
    chk("reset_newdata", 32'(newdata), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tx_bit(1'b1, 20);

    // Single character
    send(8'h74, 1'b1, BIT_CLK);
    tx_bit(1'b1, 40);
    chk("single_cnt", 32'(nd_cnt), 32'd1);
    chk("single_val", 32'(nd_val[$]), 32'h74);
    chk("single_fe", 32'(fe_cnt), 32'd0);
    chk("single_busy", 32'(busy), 32'h0);

    // Back-to-back, no idle gap
    send(8'h74, 1'b1, BIT_CLK);
    send(8'h31, 1'b1, BIT_CLK);
    send(8'h0D, 1'b1, BIT_CLK);
    tx_bit(1'b1, 40);
    chk("b2b_cnt", 32'(nd_cnt), 32'd4);
    chk("b2b_v0", 32'(nd_val[1]), 32'h74);
    chk("b2b_v1", 32'(nd_val[2]), 32'h31);
    chk("b2b_v2", 32'(nd_val[3]), 32'h0D);
    chk("b2b_gap0", 32'(nd_cyc[2] - nd_cyc[1]), 32'd1600);
    chk("b2b_gap1", 32'(nd_cyc[3] - nd_cyc[2]), 32'd1600);

    // Bit 7 discarded
    b = 8'hB2;
    send(b, 1'b1, BIT_CLK);
    tx_bit(1'b1, 40);
    chk("bit7_val", 32'(nd_val[$]), 32'h32);
    chk("bit7_cnt", 32'(nd_cnt), 32'd5);

    // Glitch reject
    n0 = nd_cnt;
    f0 = fe_cnt;
    tx_bit(1'b0, 50);
    tx_bit(1'b1, 20);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    tx_bit(1'b1, 15);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    tx_bit(1'b1, 100);
    chk("glitch_no_nd", 32'(nd_cnt), 32'(n0));
    chk("glitch_no_fe", 32'(fe_cnt), 32'(f0));
    send(8'h31, 1'b1, BIT_CLK);
    tx_bit(1'b1, 40);
    chk("glitch_next_val", 32'(nd_val[$]), 32'h31);

    // Framing error: stop bit low, line held low 400 clk
    n0 = nd_cnt;
    send(8'h32, 1'b0, 360);
    chk("ferr_busy_wait", 32'(busy), 32'h1);
    tx_bit(1'b0, 40);
    tx_bit(1'b1, 20);
    chk("ferr_busy_lo", 32'(busy), 32'h0);
    chk("ferr_cnt", 32'(fe_cnt), 32'(f0 + 1));
    chk("ferr_no_nd", 32'(nd_cnt), 32'(n0));
    chk("ferr_hold", 32'(datain), 32'h31);
    tx_bit(1'b1, 140);
    send(8'h0D, 1'b1, BIT_CLK);
    tx_bit(1'b1, 40);
    chk("ferr_next_val", 32'(nd_val[$]), 32'h0D);

    // Reset during data bit 4 of 0x74
    n0 = nd_cnt;
    b  = 8'h74;
    tx_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) tx_bit(b[i], BIT_CLK);
    tx_bit(b[4], 80);
    rst = 1'b1;
    evq.delete();
    model_dat = 7'h00;
    #1;
    chk("rst_mid_datain", 32'(datain), 32'h00);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_nd", 32'(newdata), 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_bit(1'b1, 200);
    chk("rst_no_strobe", 32'(nd_cnt), 32'(n0));
    send(8'h31, 1'b1, BIT_CLK);
    tx_bit(1'b1, 40);
    chk("rst_next_val", 32'(nd_val[$]), 32'h31);
    chk("rst_next_cnt", 32'(nd_cnt), 32'(n0 + 1));

    chk("model_drained", 32'(evq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
